// File: rtl/key_map_pkg.sv
// Scan-code map, action indices and key FSM state type shared by the key action decoder.
package key_map_pkg;

    localparam int ACT_UP    = 0;
    localparam int ACT_DOWN  = 1;
    localparam int ACT_LEFT  = 2;
    localparam int ACT_RIGHT = 3;
    localparam int NUM_ACTS  = 4;

    localparam logic [7:0] SC_P0_UP    = 8'h1D;
    localparam logic [7:0] SC_P0_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P0_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P0_RIGHT = 8'h23;
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;

    localparam logic [7:0] SC_START = 8'h29;
    localparam logic [7:0] SC_PAUSE = 8'h4D;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_e;

    function automatic logic [7:0] key_code(input int player, input int act);
        logic [7:0] code;
        case (act)
            ACT_UP:    code = (player == 0) ? SC_P0_UP    : SC_P1_UP;
            ACT_DOWN:  code = (player == 0) ? SC_P0_DOWN  : SC_P1_DOWN;
            ACT_LEFT:  code = (player == 0) ? SC_P0_LEFT  : SC_P1_LEFT;
            default:   code = (player == 0) ? SC_P0_RIGHT : SC_P1_RIGHT;
        endcase
        return code;
    endfunction

    // Player 1 uses the arrow cluster, which always carries the E0 prefix.
    function automatic logic key_needs_e0(input int player);
        return (player == 1);
    endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Per-key make/break tracker with optional DAS/ARR auto-repeat (KEYDEC_AUTOREPEAT_EN).
module key_repeat_fsm
    import key_map_pkg::*;
#(
    parameter bit REPEAT_EN  = 1'b1,
    parameter int DAS_CYCLES = 20000000,
    parameter int ARR_CYCLES = 5000000,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic make,
    input  logic brk,
    input  logic hold_off,
    output logic pulse,
    output logic held
);

`ifdef KEYDEC_AUTOREPEAT_EN
    localparam bit USE_FSM = REPEAT_EN;
`else
    localparam bit USE_FSM = 1'b0;
`endif

    logic unused_cfg;
    assign unused_cfg = hold_off ^ REPEAT_EN ^ (DAS_CYCLES > 1) ^ (ARR_CYCLES > 0) ^ (CNT_W > 0);

    if (USE_FSM) begin : gen_rep
        key_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;
        logic             das_hit, arr_hit;

        assign das_hit = (cnt_q == CNT_W'(DAS_CYCLES - 1));
        assign arr_hit = (cnt_q == CNT_W'(ARR_CYCLES - 1));

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        // A paused key (hold_off) freezes both state and count until released.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (make) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (brk) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!hold_off) begin
                        if (das_hit) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (brk) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!hold_off) begin
                        cnt_d = arr_hit ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            pulse_d = 1'b0;
            if (state_q == IDLE) begin
                pulse_d = make;
            end else if (!brk && !hold_off) begin
                pulse_d = (state_q == DELAY) ? das_hit : arr_hit;
            end
        end

        assign pulse = pulse_q;
        assign held  = (state_q != IDLE);
    end else begin : gen_plain
        logic held_q, held_d;
        logic pulse_q, pulse_d;

        always_comb begin
            held_d  = held_q;
            pulse_d = make & ~held_q;
            if (make) begin
                held_d = 1'b1;
            end else if (brk) begin
                held_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                held_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                held_q  <= held_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse = pulse_q;
        assign held  = held_q;
    end

endmodule

// File: rtl/key_action_decoder.sv
// Decodes PS/2 key events into registered per-player action pulses/held flags and global pulses.
// Auto-repeat with left/right arbitration is enabled by defining KEYDEC_AUTOREPEAT_EN.
module key_action_decoder
    import key_map_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DAS_CYCLES  = 20000000,
    parameter int ARR_CYCLES  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [10:0]              key_event,
    output logic [4*NUM_PLAYERS-1:0] act_pulse,
    output logic [4*NUM_PLAYERS-1:0] act_held,
    output logic                     start_pulse,
    output logic                     pause_pulse,
    output logic                     esc_pulse
);

    logic       ev_valid, ev_e0, ev_brk;
    logic [7:0] ev_code;

    assign ev_valid = key_event[10];
    assign ev_e0    = key_event[9];
    assign ev_brk   = key_event[8];
    assign ev_code  = key_event[7:0];

    logic [4*NUM_PLAYERS-1:0] key_make, key_brk, hold_off;

    genvar gi, ga;
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : gen_player
        for (ga = 0; ga < NUM_ACTS; ga++) begin : gen_act
            logic hit;
            assign hit = ev_valid && (ev_code == key_code(gi, ga)) && (ev_e0 == key_needs_e0(gi));
            assign key_make[4*gi+ga] = hit & ~ev_brk;
            assign key_brk[4*gi+ga]  = hit & ev_brk;

            key_repeat_fsm #(
                .REPEAT_EN  (ga != ACT_UP),
                .DAS_CYCLES (DAS_CYCLES),
                .ARR_CYCLES (ARR_CYCLES),
                .CNT_W      (CNT_W)
            ) u_key (
                .clk      (clk),
                .rst      (rst),
                .make     (key_make[4*gi+ga]),
                .brk      (key_brk[4*gi+ga]),
                .hold_off (hold_off[4*gi+ga]),
                .pulse    (act_pulse[4*gi+ga]),
                .held     (act_held[4*gi+ga])
            );
        end

`ifdef KEYDEC_AUTOREPEAT_EN
        localparam int IL = 4*gi + ACT_LEFT;
        localparam int IR = 4*gi + ACT_RIGHT;
        logic left_new, right_new, left_eff, right_eff;
        logic right_newer_q, right_newer_d;

        // Use this cycle's make/break so the older key pauses on the same cycle the newer one starts.
        assign left_new      = key_make[IL] & ~act_held[IL];
        assign right_new     = key_make[IR] & ~act_held[IR];
        assign left_eff      = left_new  | (act_held[IL] & ~key_brk[IL]);
        assign right_eff     = right_new | (act_held[IR] & ~key_brk[IR]);
        assign right_newer_d = right_new ? 1'b1 : (left_new ? 1'b0 : right_newer_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                right_newer_q <= 1'b0;
            end else begin
                right_newer_q <= right_newer_d;
            end
        end

        assign hold_off[4*gi+ACT_UP]   = 1'b0;
        assign hold_off[4*gi+ACT_DOWN] = 1'b0;
        assign hold_off[IL]            = right_eff & right_newer_d;
        assign hold_off[IR]            = left_eff & ~right_newer_d;
`else
        assign hold_off[4*gi +: 4] = 4'b0000;
`endif
    end

    logic glob_make;
    logic start_q, start_d, pause_q, pause_d, esc_q, esc_d;

    assign glob_make = ev_valid & ~ev_e0 & ~ev_brk;
    assign start_d   = glob_make && (ev_code == SC_START);
    assign pause_d   = glob_make && (ev_code == SC_PAUSE);
    assign esc_d     = glob_make && (ev_code == SC_ESC);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            pause_q <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            pause_q <= pause_d;
            esc_q   <= esc_d;
        end
    end

    assign start_pulse = start_q;
    assign pause_pulse = pause_q;
    assign esc_pulse   = esc_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Bench for key_action_decoder: timeline model of key holds plus directed scenarios.
module tb_key_action_decoder;

    localparam int DAS = 5;
    localparam int ARR = 3;
`ifdef KEYDEC_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] key_event = '0;
    logic [7:0]  act_pulse, act_held;
    logic        start_pulse, pause_pulse, esc_pulse;
    logic [3:0]  act_pulse1, act_held1;
    logic        start1, pause1, esc1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_action_decoder #(.NUM_PLAYERS(2), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .key_event(key_event),
        .act_pulse(act_pulse), .act_held(act_held),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse), .esc_pulse(esc_pulse)
    );

    key_action_decoder #(.NUM_PLAYERS(1), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .key_event(key_event),
        .act_pulse(act_pulse1), .act_held(act_held1),
        .start_pulse(start1), .pause_pulse(pause1), .esc_pulse(esc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each held key remembers when it was pressed and how many unpaused cycles it has been held.
    logic [7:0] exp_pulse = '0, exp_held = '0;
    logic       exp_start = 1'b0, exp_pause = 1'b0, exp_esc = 1'b0;
    bit         m_held [2][4];
    int         m_el   [2][4];
    int         m_pt   [2][4];
    int         m_cyc  = 0;

    function automatic logic [7:0] code_of(input int p, input int a);
        logic [7:0] tbl [8];
        tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
        return tbl[4*p+a];
    endfunction

    task automatic model_step();
        bit         v, e0, b, hit, paused;
        logic [7:0] c;
        logic [7:0] np;
        bit         made [2][4];
        int         opp;
        v  = key_event[10];
        e0 = key_event[9];
        b  = key_event[8];
        c  = key_event[7:0];
        np = '0;
        if (rst) begin
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < 4; a++) m_held[p][a] = 1'b0;
            exp_pulse = '0;
            exp_held  = '0;
            exp_start = 1'b0;
            exp_pause = 1'b0;
            exp_esc   = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int a = 0; a < 4; a++) begin
                    hit = v && (c == code_of(p, a)) && (e0 == (p == 1));
                    made[p][a] = 1'b0;
                    if (hit && !b && !m_held[p][a]) begin
                        m_held[p][a] = 1'b1;
                        m_el[p][a]   = 0;
                        m_pt[p][a]   = m_cyc;
                        np[4*p+a]    = 1'b1;
                        made[p][a]   = 1'b1;
                    end else if (hit && b) begin
                        m_held[p][a] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                for (int a = 1; a < 4; a++) begin
                    if (AUTO && m_held[p][a] && !made[p][a]) begin
                        opp    = (a == 2) ? 3 : ((a == 3) ? 2 : -1);
                        paused = (opp >= 0) && m_held[p][opp] && (m_pt[p][opp] > m_pt[p][a]);
                        if (!paused) begin
                            m_el[p][a]++;
                            if (m_el[p][a] == DAS || (m_el[p][a] > DAS && (m_el[p][a] - DAS) % ARR == 0))
                                np[4*p+a] = 1'b1;
                        end
                    end
                end
            end
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < 4; a++) exp_held[4*p+a] = m_held[p][a];
            exp_pulse = np;
            exp_start = v && !e0 && !b && (c == 8'h29);
            exp_pause = v && !e0 && !b && (c == 8'h4D);
            exp_esc   = v && !e0 && !b && (c == 8'h76);
        end
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("act_pulse", act_pulse, exp_pulse);
            chk("act_held", act_held, exp_held);
            chk("start_pulse", start_pulse, exp_start);
            chk("pause_pulse", pause_pulse, exp_pause);
            chk("esc_pulse", esc_pulse, exp_esc);
            chk("np1_act_pulse", act_pulse1, exp_pulse[3:0]);
            chk("np1_act_held", act_held1, exp_held[3:0]);
            chk("np1_start", start1, exp_start);
            chk("np1_pause", pause1, exp_pause);
            chk("np1_esc", esc1, exp_esc);
            model_step();
        end
    end

    task automatic send(input logic [10:0] ev);
        key_event = ev;
        $display("EV key_event=%h t=%0t", ev, $time);
        @(posedge clk); #1;
        key_event = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Cycle 0 carries ev0; masks record bit values seen in cycles 1..15.
    task automatic scn(input logic [10:0] ev0, input int c1, input logic [10:0] ev1,
                       input int c2, input logic [10:0] ev2, input int bit_a, input int bit_b,
                       output logic [15:0] pa, output logic [15:0] pb, output logic [15:0] ha);
        pa = '0;
        pb = '0;
        ha = '0;
        key_event = ev0;
        $display("EV key_event=%h t=%0t", ev0, $time);
        @(posedge clk); #1;
        for (int c = 1; c < 16; c++) begin
            pa[c] = act_pulse[bit_a];
            pb[c] = act_pulse[bit_b];
            ha[c] = act_held[bit_a];
            key_event = (c == c1) ? ev1 : ((c == c2) ? ev2 : 11'h000);
            if (key_event != 11'h000) $display("EV key_event=%h t=%0t", key_event, $time);
            @(posedge clk); #1;
        end
        key_event = '0;
    endtask

    logic [15:0] pa, pb, ha;

    initial begin
        key_event = 11'h41D;
        idle(2);
        chk("reset_pulse", act_pulse, 8'h00);
        chk("reset_held", act_held, 8'h00);
        rst = 1'b0;
        key_event = '0;
        idle(1);
        chk("reset_release_pulse", act_pulse, 8'h00);
        chk("reset_release_held", act_held, 8'h00);

        send(11'h41D);
        chk("w_make_pulse", act_pulse, 8'h01);
        chk("w_make_held", act_held, 8'h01);
        idle(1);
        chk("w_pulse_one_cycle", act_pulse, 8'h00);
        idle(8);
        send(11'h41D);
        chk("w_typematic_no_pulse", act_pulse, 8'h00);
        chk("w_typematic_held", act_held, 8'h01);
        send(11'h51D);
        chk("w_break_held", act_held, 8'h00);
        chk("w_break_no_pulse", act_pulse, 8'h00);
        send(11'h61D);
        chk("w_with_e0_ignored", act_pulse, 8'h00);

        send(11'h66B);
        chk("p1_left_pulse", act_pulse, 8'h40);
        chk("np1_arrow_ignored", act_pulse1, 4'h0);
        send(11'h76B);
        chk("p1_left_break", act_held, 8'h00);
        send(11'h46B);
        chk("arrow_no_e0_pulse", act_pulse, 8'h00);
        chk("arrow_no_e0_held", act_held, 8'h00);

        scn(11'h41C, 10, 11'h51C, 99, 11'h000, 2, 3, pa, pb, ha);
        chk("hold_a_pulses", pa, AUTO ? 16'h0242 : 16'h0002);
        chk("hold_a_held", ha, 16'h07FE);
        chk("hold_a_no_d", pb, 16'h0000);
        idle(3);

        scn(11'h41C, 3, 11'h423, 10, 11'h523, 2, 3, pa, pb, ha);
        chk("conflict_a_pulses", pa, AUTO ? 16'h2002 : 16'h0002);
        chk("conflict_d_pulses", pb, AUTO ? 16'h0210 : 16'h0010);
        chk("conflict_a_held", ha, 16'hFFFE);
        send(11'h51C);
        idle(2);

        send(11'h429);
        chk("space_start", start_pulse, 1'b1);
        send(11'h429);
        chk("space_typematic_start", start_pulse, 1'b1);
        send(11'h529);
        chk("space_break_none", start_pulse, 1'b0);
        send(11'h44D);
        chk("p_pause", pause_pulse, 1'b1);
        send(11'h476);
        chk("esc_pulse", esc_pulse, 1'b1);
        send(11'h676);
        chk("esc_e0_ignored", esc_pulse, 1'b0);

        send(11'h423);
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("mid_hold_reset_held", act_held, 8'h00);
        rst = 1'b0;
        idle(1);
        chk("post_reset_pulse", act_pulse, 8'h00);
        send(11'h523);
        chk("break_not_held", act_held, 8'h00);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
